// File: rtl/rot_pkg.sv
// Shared definitions for the rotation-engine DMA burst scheduler.
package rot_pkg;

  // Scheduler FSM encoding.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT,
    ST_FIN,
    ST_ABORT
  } state_e;

  // No AHB burst may cross a 1 KB address boundary.
  localparam int KB_BOUNDARY = 1024;

  // Width of the beat-count field handed to the DMA master (1..16).
  localparam int CNT_W = 5;

  // DMA channel identifiers.
  typedef enum logic {
    CH_RD = 1'b0,
    CH_WR = 1'b1
  } chan_e;

endpackage

// File: rtl/rot_burst_calc.sv
// Burst sizing for one channel: picks the largest legal beat count that
// fits in the remaining pixels, the maximum burst length and the space
// left before the next 1 KB boundary, and returns the address that
// follows the burst.
module rot_burst_calc
  import rot_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int LEFT_W        = 20,
  parameter int BURST_LEN     = 16,
  parameter int BYTES_PER_PIX = 4
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEFT_W-1:0] i_left,
  output logic [CNT_W-1:0]  o_count,
  output logic [ADDR_W-1:0] o_next_addr
);

  localparam int OFS_W = $clog2(KB_BOUNDARY);

  logic [OFS_W:0] w_room_bytes;
  logic [31:0]    w_room_pix;
  logic [31:0]    w_min;

  // Min-of-three beat count and the post-burst address.
  always_comb begin
    // NOTE: every combinational output gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    w_room_bytes = (OFS_W+1)'(KB_BOUNDARY) - {1'b0, i_addr[OFS_W-1:0]};
    w_room_pix   = 32'(w_room_bytes) / 32'(BYTES_PER_PIX);
    w_min        = 32'(BURST_LEN);
    if (32'(i_left) < w_min) w_min = 32'(i_left);
    if (w_room_pix < w_min)  w_min = w_room_pix;
    o_count     = CNT_W'(w_min);
    o_next_addr = i_addr + ADDR_W'(w_min) * ADDR_W'(BYTES_PER_PIX);
  end

endmodule

// File: rtl/rot_dma_sched.sv
// Burst scheduler for the rotation engine's AHB DMA master. Splits the
// frame read and write into boundary-safe bursts, arbitrates between the
// two channels and sequences the master one burst at a time.
module rot_dma_sched
  import rot_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DIM_W         = 10,
  parameter int BURST_LEN     = 16,
  parameter int BYTES_PER_PIX = 4
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET,
  input  logic              I_CTRL_START,
  input  logic              I_CTRL_RESET,
  input  logic              I_CTRL_INTR_MASK,
  input  logic              I_CTRL_INTR_CLEAR,
  input  logic [ADDR_W-1:0] I_DMA_SRC_IMG,
  input  logic [ADDR_W-1:0] I_DMA_DST_IMG,
  input  logic [DIM_W-1:0]  I_ROT_IMG_H,
  input  logic [DIM_W-1:0]  I_ROT_IMG_W,
  input  logic              I_RD_REQ,
  input  logic              I_WR_REQ,
  input  logic              I_DMA_DONE,
  output logic              O_DMA_START,
  output logic [ADDR_W-1:0] O_DMA_ADDR,
  output logic [CNT_W-1:0]  O_DMA_COUNT,
  output logic              O_DMA_WRITE,
  output logic              O_RD_GNT,
  output logic              O_WR_GNT,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_INTERRUPT
);

  localparam int LEFT_W = 2 * DIM_W;

  state_e              r_state;
  chan_e               r_last_ch;
  logic [LEFT_W-1:0]   r_rd_left;
  logic [LEFT_W-1:0]   r_wr_left;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_dma_start;
  logic [ADDR_W-1:0]   r_dma_addr;
  logic [CNT_W-1:0]    r_dma_count;
  logic                r_dma_write;
  logic                r_rd_gnt;
  logic                r_wr_gnt;
  logic                r_busy;
  logic                r_done;
  logic                r_intr;

  logic [LEFT_W-1:0]   w_total;
  logic                w_rd_elig;
  logic                w_wr_elig;
  chan_e               w_grant_ch;
  chan_e               w_calc_ch;
  logic [ADDR_W-1:0]   w_calc_addr;
  logic [LEFT_W-1:0]   w_calc_left;
  logic [CNT_W-1:0]    w_calc_count;
  logic [ADDR_W-1:0]   w_next_addr;
  logic [LEFT_W-1:0]   w_rd_left_nxt;
  logic [LEFT_W-1:0]   w_wr_left_nxt;

  assign w_total = LEFT_W'(I_ROT_IMG_H) * LEFT_W'(I_ROT_IMG_W);

  // Channel eligibility, round-robin pick and the burst-calculator mux.
  always_comb begin
    w_rd_elig = (r_rd_left != '0) && I_RD_REQ;
    // Pixels written never overtake pixels read: written < read is the
    // same as rd_left < wr_left because both count down from the total.
    w_wr_elig = (r_wr_left != '0) && I_WR_REQ && (r_rd_left < r_wr_left);
    w_grant_ch = CH_RD;
    if (w_rd_elig && w_wr_elig) begin
      w_grant_ch = (r_last_ch == CH_RD) ? CH_WR : CH_RD;
    end else if (w_wr_elig) begin
      w_grant_ch = CH_WR;
    end
    // While a burst is outstanding the calculator follows its channel so
    // its next-address output is the post-burst address.
    w_calc_ch   = (r_state == ST_ARB) ? w_grant_ch : r_last_ch;
    w_calc_addr = (w_calc_ch == CH_WR) ? r_wr_addr : r_rd_addr;
    w_calc_left = (w_calc_ch == CH_WR) ? r_wr_left : r_rd_left;
    w_rd_left_nxt = r_rd_left;
    w_wr_left_nxt = r_wr_left;
    if (r_last_ch == CH_WR) w_wr_left_nxt = r_wr_left - LEFT_W'(r_dma_count);
    else                    w_rd_left_nxt = r_rd_left - LEFT_W'(r_dma_count);
  end

  rot_burst_calc #(
    .ADDR_W        (ADDR_W),
    .LEFT_W        (LEFT_W),
    .BURST_LEN     (BURST_LEN),
    .BYTES_PER_PIX (BYTES_PER_PIX)
  ) u_burst_calc (
    .i_addr      (w_calc_addr),
    .i_left      (w_calc_left),
    .o_count     (w_calc_count),
    .o_next_addr (w_next_addr)
  );

  // Scheduler FSM with registered outputs and frame bookkeeping.
  always_ff @(posedge I_HCLK) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values, regardless of statement order.
    if (I_HRESET) begin
      r_state     <= ST_IDLE;
      r_last_ch   <= CH_WR;
      r_rd_left   <= '0;
      r_wr_left   <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_dma_start <= 1'b0;
      r_dma_addr  <= '0;
      r_dma_count <= '0;
      r_dma_write <= 1'b0;
      r_rd_gnt    <= 1'b0;
      r_wr_gnt    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_intr      <= 1'b0;
    end else begin
      r_dma_start <= 1'b0;
      r_rd_gnt    <= 1'b0;
      r_wr_gnt    <= 1'b0;
      r_done      <= 1'b0;
      // A set in FIN below is written later and therefore wins.
      if (I_CTRL_INTR_CLEAR) r_intr <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (I_CTRL_START && !I_CTRL_RESET) begin
            r_rd_left <= w_total;
            r_wr_left <= w_total;
            r_rd_addr <= I_DMA_SRC_IMG;
            r_wr_addr <= I_DMA_DST_IMG;
            r_busy    <= 1'b1;
            r_state   <= (w_total == '0) ? ST_FIN : ST_ARB;
          end
        end
        ST_ARB: begin
          if (I_CTRL_RESET) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_rd_elig || w_wr_elig) begin
            r_dma_start <= 1'b1;
            r_rd_gnt    <= (w_grant_ch == CH_RD);
            r_wr_gnt    <= (w_grant_ch == CH_WR);
            r_dma_addr  <= w_calc_addr;
            r_dma_count <= w_calc_count;
            r_dma_write <= (w_grant_ch == CH_WR);
            r_last_ch   <= w_grant_ch;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (I_CTRL_RESET) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (I_DMA_DONE) begin
            if (r_last_ch == CH_WR) r_wr_addr <= w_next_addr;
            else                    r_rd_addr <= w_next_addr;
            r_rd_left <= w_rd_left_nxt;
            r_wr_left <= w_wr_left_nxt;
            // Abort and completion in the same cycle: the burst is over,
            // so there is nothing left to wait for.
            if (I_CTRL_RESET) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else if (w_rd_left_nxt == '0 && w_wr_left_nxt == '0) begin
              r_state <= ST_FIN;
            end else begin
              r_state <= ST_ARB;
            end
          end else if (I_CTRL_RESET) begin
            r_state <= ST_ABORT;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
          if (!I_CTRL_RESET) begin
            r_done <= 1'b1;
            if (!I_CTRL_INTR_MASK) r_intr <= 1'b1;
          end
        end
        ST_ABORT: begin
          if (I_DMA_DONE) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign O_DMA_START = r_dma_start;
  assign O_DMA_ADDR  = r_dma_addr;
  assign O_DMA_COUNT = r_dma_count;
  assign O_DMA_WRITE = r_dma_write;
  assign O_RD_GNT    = r_rd_gnt;
  assign O_WR_GNT    = r_wr_gnt;
  assign O_BUSY      = r_busy;
  assign O_DONE      = r_done;
  assign O_INTERRUPT = r_intr;

endmodule

// File: doc/rot_dma_sched.md
Name: rot_dma_sched

Overview:
- Burst scheduler for the rotation engine's AHB DMA master.
- On a start command it splits the source-image read and the destination-image write into AHB-legal bursts.
- Arbitrates between the read channel (line buffer has room) and the write channel (output buffer has a burst ready).
- Sequences the DMA master one burst at a time through a start/done handshake; raises done/interrupt when the whole frame has been moved.

Parameters:
- ADDR_W, 32, address width.
- DIM_W, 10, width of image height/width fields.
- BURST_LEN, 16, maximum beats per burst; power of two, ≤16.
- BYTES_PER_PIX, 4, bytes per pixel word (one RGB pixel per 32-bit word).

Ports:
- I_HCLK  in  1  system clock.
- I_HRESET  in  1  synchronous, active-high reset.
- I_CTRL_START  in  1  one-cycle start pulse from the register block.
- I_CTRL_RESET  in  1  soft abort, level, sampled each cycle.
- I_CTRL_INTR_MASK  in  1  1 = suppress O_INTERRUPT.
- I_CTRL_INTR_CLEAR  in  1  clears O_INTERRUPT.
- I_DMA_SRC_IMG  in  ADDR_W  source base address, word aligned.
- I_DMA_DST_IMG  in  ADDR_W  destination base address, word aligned.
- I_ROT_IMG_H  in  DIM_W  image height in pixels.
- I_ROT_IMG_W  in  DIM_W  image width in pixels.
- I_RD_REQ  in  1  line buffer can accept BURST_LEN pixels.
- I_WR_REQ  in  1  output buffer holds data for a write burst.
- I_DMA_DONE  in  1  one-cycle pulse: current burst fully completed on AHB.
- O_DMA_START  out  1  one-cycle burst launch pulse.
- O_DMA_ADDR  out  ADDR_W  burst start address.
- O_DMA_COUNT  out  5  burst beats, 1..BURST_LEN.
- O_DMA_WRITE  out  1  1 = write burst, 0 = read burst.
- O_RD_GNT  out  1  one-cycle pulse with O_DMA_START for read bursts.
- O_WR_GNT  out  1  one-cycle pulse with O_DMA_START for write bursts.
- O_BUSY  out  1  frame transfer in progress.
- O_DONE  out  1  one-cycle frame-complete pulse.
- O_INTERRUPT  out  1  sticky frame-complete interrupt.

Behaviour:

Reset and registers
- All outputs are registered and 0 on reset.
- I_HRESET forces IDLE and clears all counters and O_INTERRUPT.

Frame setup
- On start, latch base addresses and total = H*W (2*DIM_W bits).
- rd_left and wr_left are both loaded with total.
- rd_addr = src base, wr_addr = dst base.

FSM states: IDLE, ARB, ISSUE, WAIT, FIN, ABORT.
- IDLE
  - I_CTRL_START → ARB next cycle, O_BUSY=1.
  - If total==0 → FIN instead.
- ARB (evaluated every cycle)
  - Read eligible: rd_left>0 && I_RD_REQ.
  - Write eligible: wr_left>0 && I_WR_REQ && (total-wr_left) < (total-rd_left), i.e. writes never overtake completed reads.
  - One eligible → grant it.
  - Both eligible → round-robin: last-granted channel loses.
  - Neither eligible → stay in ARB.
  - Grant → ISSUE.
- ISSUE (one cycle)
  - O_DMA_START=1 and the matching O_RD_GNT/O_WR_GNT=1.
  - O_DMA_ADDR/COUNT/WRITE driven from this cycle and held stable until I_DMA_DONE.
  - → WAIT.
- WAIT
  - On I_DMA_DONE: addr += count*BYTES_PER_PIX, left -= count.
  - If both left==0 → FIN, else → ARB.
- FIN
  - O_DONE=1 for one cycle, O_BUSY=0 next cycle.
  - O_INTERRUPT set unless masked.
  - → IDLE.
- Minimum latency: start at cycle 0 → O_DMA_START at cycle 2, provided the request is already high.

Burst count
- count = min(BURST_LEN, left, (1024 − addr[9:0]) / BYTES_PER_PIX).
- No burst may cross a 1 KB boundary.

Boundary conditions
- I_CTRL_START while O_BUSY: ignored.
- I_CTRL_RESET in IDLE/ARB/ISSUE/FIN: → IDLE the next cycle, O_BUSY=0, no O_DONE.
- I_CTRL_RESET in WAIT: → ABORT, which waits for I_DMA_DONE and then → IDLE. The DMA master is never orphaned mid-burst. No O_DONE, no interrupt.
- I_DMA_DONE outside WAIT/ABORT: ignored.
- Interrupt register: if I_CTRL_INTR_CLEAR and a set in FIN occur in the same cycle, set wins. Clear at any other time → 0 next cycle.
- Mask applies at set time; it does not clear an already-pending interrupt.

Decomposition:
- Shared package rot_pkg holds:
  - the FSM state encoding;
  - the constant KB_BOUNDARY=1024;
  - the beat-count width;
  - the channel enum RD/WR.
- One sub-module: rot_burst_calc, a combinational min-of-three count and next-address calculator, instantiated once and fed by a channel mux.

Test Plan:
1. 4×4 frame, src 0x1000, dst 0x2000, RD_REQ=WR_REQ=1 → read burst (addr 0x1000, count 16, WRITE=0) at cycle 2. After its DONE, write burst (addr 0x2000, count 16). O_DONE once, O_INTERRUPT=1.
2. 8×4 frame, src 0x13F0 → read bursts of (0x13F0, 4), (0x1400, 16), (0x1440, 12). No burst crosses 0x1400.
3. H=0 → O_DONE 2 cycles after start, O_DMA_START never asserted, O_INTERRUPT=1.
4. 8×8 frame, both requests held high → after the first read, grants alternate RD, WR, RD, WR…. No write is granted while written pixels ≥ read pixels. 4 RD + 4 WR grants total.
5. I_CTRL_RESET during WAIT of the first burst, DONE 5 cycles later → O_BUSY stays 1 until the cycle after DONE. No further O_DMA_START, no O_DONE. A new start then runs normally.
6. Mask=1, then run case 1 → O_DONE pulses, O_INTERRUPT stays 0. A second start issued while busy produces no extra bursts.
